fifo_rd_stream: RTL and testbench

//  Read-side drain stage for the async FIFO, in the r_clk domain.

---
 rtl/fifo_rd_stream.sv | 71 +++++++
 tb/tb_fifo_rd_stream.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read port into a valid/ready stream.
// A 2-entry skid buffer absorbs the FIFO's one-cycle registered read latency.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t                r_state;
    logic [1:0]            r_occ;
    logic                  r_infl;
    logic [DATA_WIDTH-1:0] r_b0, r_b1;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_run, w_pop, w_push;
    logic [2:0]            w_level;

    assign w_run      = r_state == RUN;
    assign m_valid    = w_run && r_occ != 2'd0;
    assign m_data     = r_b0;
    assign w_pop      = m_valid && m_ready;
    assign w_push     = w_run && r_infl;
    // occupancy the buffer will hold once the in-flight word lands and this cycle's pop leaves
    assign w_level    = {1'b0, r_occ} + {2'b0, r_infl} - {2'b0, w_pop};
    assign fifo_rd_en = !r_rst && w_run && !flush && !fifo_empty && w_level < 3'd2;
    assign busy       = r_occ != 2'd0 || r_infl;
    assign rd_count   = r_count;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_state <= RUN;
            r_occ   <= 2'd0;
            r_infl  <= 1'b0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_count <= '0;
        end else begin
            r_infl  <= fifo_rd_en;
            r_count <= r_count + CNT_WIDTH'(w_pop);
            if (!w_run) begin
                r_occ <= 2'd0;
                if (!flush && !r_infl)
                    r_state <= RUN;
            end else begin
                if (flush)
                    r_state <= FLUSH;
                r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
                if ((w_pop && (r_occ == 2'd2 || w_push)) || (w_push && r_occ == 2'd0))
                    r_b0 <= (w_pop && r_occ == 2'd2) ? r_b1 : fifo_rd_data;
                if (w_push && r_occ == (w_pop ? 2'd2 : 2'd1))
                    r_b1 <= fifo_rd_data;
            end
        end
    end

    always_ff @(posedge r_clk)
        if (!r_rst)
            assert (r_occ <= 2'd2 && !(w_push && !w_pop && r_occ == 2'd2))
            else $error("fifo_rd_stream skid buffer overflow");
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: table vectors, hand sequences and random traffic against a queue model.
module tb_fifo_rd_stream;
    logic        clk = 1'b0;
    logic        rst, fifo_empty, fifo_rd_en, flush, m_valid, m_ready, busy;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic [7:0]  m_data;
    logic [15:0] rd_count;
    logic [7:0]  mem [0:255];
    int          fhead = 0, ftail = 0;
    int          n_chk = 0, n_pass = 0;
    logic [7:0]  exp_q [$];
    int          exp_cnt = 0;
    logic        prev_rd = 1'b0, hold = 1'b0;
    logic [7:0]  hold_d = 8'h00, first_w;

    typedef struct {
        logic       rdy;
        logic       rd_en;
        logic       vld;
        logic [7:0] dat;
        logic       bsy;
    } vec_t;
    vec_t t2 [6];

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .r_clk(clk), .r_rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .flush(flush), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .rd_count(rd_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // behavioural FIFO: registered read data, one word per enabled cycle
    assign fifo_empty = fhead == ftail;
    always @(posedge clk)
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[fhead[7:0]];
            fhead        <= fhead + 1;
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic put(input logic [7:0] w);
        mem[ftail[7:0]] = w;
        ftail++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // drive one cycle's inputs, then check the stream against the queue model mid-cycle
    task automatic cyc(input logic rdy, input logic fl);
        m_ready = rdy;
        flush   = fl;
        #4;
        if (fifo_empty) chk("rd_en_while_empty", fifo_rd_en, 0);
        chk("valid_vs_model", m_valid, (exp_q.size() - int'(prev_rd)) != 0);
        chk("occ_bound", (exp_q.size() - int'(prev_rd)) <= 2, 1);
        chk("rd_count", rd_count, exp_cnt[15:0]);
        if (hold) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, hold_d);
        end
        if (m_valid && m_ready) begin
            chk("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("order", m_data, exp_q.pop_front());
            exp_cnt++;
        end
        hold   = m_valid && !m_ready && !fl;
        hold_d = m_data;
        if (fl) exp_q.delete();
        if (fifo_rd_en) exp_q.push_back(mem[fhead[7:0]]);
        prev_rd = fifo_rd_en;
    endtask

    task automatic model_reset;
        exp_q.delete();
        prev_rd = 1'b0;
        hold    = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic rst_cycles(input int n);
        rst     = 1'b1;
        m_ready = 1'b0;
        flush   = 1'b0;
        for (int i = 0; i < n; i++) begin
            #4;
            chk("rd_en_in_reset", fifo_rd_en, 0);
            tick;
        end
        rst = 1'b0;
        model_reset;
    endtask

    initial begin
        t2[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        t2[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        t2[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
        t2[3] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
        t2[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
        t2[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        rst_cycles(2);

        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'b0);
            chk("idle_rd_en", fifo_rd_en, 0);
            chk("idle_valid", m_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_data", m_data, 0);
            tick;
        end

        put(8'h11); put(8'h22); put(8'h33);
        for (int i = 0; i < 6; i++) begin
            cyc(t2[i].rdy, 1'b0);
            chk("t2_rd_en", fifo_rd_en, t2[i].rd_en);
            chk("t2_valid", m_valid, t2[i].vld);
            chk("t2_busy", busy, t2[i].bsy);
            if (t2[i].vld) chk("t2_data", m_data, t2[i].dat);
            tick;
        end
        chk("t2_count", rd_count, 3);

        first_w = 8'($urandom);
        put(first_w);
        for (int i = 0; i < 5; i++) put(8'($urandom));
        for (int i = 0; i < 3; i++) begin cyc(1'b0, 1'b0); tick; end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            chk("full_rd_en", fifo_rd_en, 0);
            chk("full_valid", m_valid, 1);
            chk("full_data", m_data, first_w);
            tick;
        end
        cyc(1'b1, 1'b0);
        chk("full_resume", fifo_rd_en, 1);
        tick;
        for (int i = 0; i < 12; i++) begin cyc(1'b1, 1'b0); tick; end
        chk("t4_count", rd_count, 9);

        for (int i = 0; i < 5; i++) put(8'hA0 + 8'(i));
        cyc(1'b1, 1'b0);
        chk("fl_first_rd", fifo_rd_en, 1);
        tick;
        cyc(1'b1, 1'b1);
        chk("fl_rd_en", fifo_rd_en, 0);
        tick;
        cyc(1'b1, 1'b0);
        chk("fl_valid", m_valid, 0);
        chk("fl_count", rd_count, 9);
        tick;
        cyc(1'b1, 1'b0);
        chk("fl_resume", fifo_rd_en, 1);
        tick;
        for (int i = 0; i < 10; i++) begin cyc(1'b1, 1'b0); tick; end
        chk("t5_count", rd_count, 13);

        rst_cycles(2);
        for (int i = 0; i < 70; i++) put(8'($urandom));
        for (int k = 0; k < 1000 && exp_cnt < 70; k++) begin
            cyc(1'($urandom_range(0, 1)), 1'b0);
            tick;
        end
        chk("t3_done", exp_cnt, 70);
        chk("t3_count", rd_count, 70);

        rst_cycles(1);
        for (int i = 0; i < 4; i++) put(8'h50 + 8'(i));
        for (int i = 0; i < 4; i++) begin cyc(1'b1, 1'b0); tick; end
        rst     = 1'b1;
        m_ready = 1'b0;
        #4;
        chk("t6_infl", prev_rd, 1);
        chk("t6_rd_en_rst", fifo_rd_en, 0);
        chk("t6_cnt_pre", rd_count, 2);
        tick;
        rst = 1'b0;
        model_reset;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            chk("t6_valid", m_valid, 0);
            chk("t6_data", m_data, 0);
            chk("t6_busy", busy, 0);
            chk("t6_rd_en", fifo_rd_en, 0);
            chk("t6_count", rd_count, 0);
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
